ps2_key_cmd_decoder: RTL and testbench

PS2_KEY_CMD_DECODER -- requirements
Module: ps2_key_cmd_decoder

---
 rtl/ps2_tetris_pkg.sv | 82 ++++++++
 rtl/cmd_fifo.sv | 71 +++++++
 rtl/ps2_key_cmd_decoder.sv | 105 ++++++++++
 tb/tb_ps2_key_cmd_decoder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_tetris_pkg.sv
// Shared command codes, PS/2 scan-code constants and prefix FSM states for
// the keyboard-to-game-command path.
package ps2_tetris_pkg;

  localparam int CMD_W    = 3;
  localparam int NUM_KEYS = 5;

  typedef enum logic [CMD_W-1:0] {
    CMD_NONE   = 3'd0,
    CMD_LEFT   = 3'd1,
    CMD_RIGHT  = 3'd2,
    CMD_DOWN   = 3'd3,
    CMD_DROP   = 3'd4,
    CMD_ROTATE = 3'd5
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_e;

  localparam logic [7:0] SC_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] SC_BREAK_PREFIX = 8'hF0;

  localparam logic [7:0] SC_LEFT   = 8'h1C;
  localparam logic [7:0] SC_RIGHT  = 8'h23;
  localparam logic [7:0] SC_DOWN   = 8'h1B;
  localparam logic [7:0] SC_DROP   = 8'h29;
  localparam logic [7:0] SC_ROTATE = 8'h1D;

  localparam logic [7:0] SC_X_LEFT   = 8'h6B;
  localparam logic [7:0] SC_X_RIGHT  = 8'h74;
  localparam logic [7:0] SC_X_DOWN   = 8'h72;
  localparam logic [7:0] SC_X_ROTATE = 8'h75;

  // Plain and E0-extended code tables are disjoint: 6B after no prefix is unmapped.
  function automatic cmd_e decode_scan(input logic [7:0] code, input logic ext);
    cmd_e result;
    result = CMD_NONE;
    if (ext) begin
      case (code)
        SC_X_LEFT:   result = CMD_LEFT;
        SC_X_RIGHT:  result = CMD_RIGHT;
        SC_X_DOWN:   result = CMD_DOWN;
        SC_X_ROTATE: result = CMD_ROTATE;
        default:     result = CMD_NONE;
      endcase
    end else begin
      case (code)
        SC_LEFT:   result = CMD_LEFT;
        SC_RIGHT:  result = CMD_RIGHT;
        SC_DOWN:   result = CMD_DOWN;
        SC_DROP:   result = CMD_DROP;
        SC_ROTATE: result = CMD_ROTATE;
        default:   result = CMD_NONE;
      endcase
    end
    return result;
  endfunction

  // keys_held bit order is {ROTATE, DROP, DOWN, RIGHT, LEFT}.
  function automatic logic [NUM_KEYS-1:0] cmd_mask(input cmd_e cmd);
    logic [NUM_KEYS-1:0] mask;
    case (cmd)
      CMD_LEFT:   mask = 5'b00001;
      CMD_RIGHT:  mask = 5'b00010;
      CMD_DOWN:   mask = 5'b00100;
      CMD_DROP:   mask = 5'b01000;
      CMD_ROTATE: mask = 5'b10000;
      default:    mask = 5'b00000;
    endcase
    return mask;
  endfunction

  // Movement keys auto-repeat; DROP and ROTATE fire once per physical press.
  function automatic logic is_repeatable(input cmd_e cmd);
    return (cmd == CMD_LEFT) || (cmd == CMD_RIGHT) || (cmd == CMD_DOWN);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small first-word-fall-through FIFO for decoded commands; the head entry is
// visible combinationally and reads as zero while empty.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             inclock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int            AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);

  // A pop frees a slot in the same cycle, so a push while full is accepted
  // when it coincides with a pop; a pop while empty is ignored.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop);

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge inclock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge inclock or posedge reset) begin
        if (reset) begin
          mem_reg[gi] <= '0;
        end else if (push_ok && (wr_ptr_reg == AW'(gi))) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  assign pop_data = empty ? '0 : mem_reg[rd_ptr_reg];

endmodule

// File: rtl/ps2_key_cmd_decoder.sv
// Turns PS/2 scan bytes (with E0/F0 prefixes) into queued game commands and
// tracks which game keys are currently held.
module ps2_key_cmd_decoder
  import ps2_tetris_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       inclock,
  input  logic       reset,
  input  logic [7:0] scan_data,
  input  logic       scan_valid,
  output logic [2:0] cmd_data,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [4:0] keys_held,
  output logic       overflow
);

  state_e              state_reg;
  state_e              state_next;
  logic [NUM_KEYS-1:0] keys_reg;
  logic [NUM_KEYS-1:0] keys_next;
  logic                overflow_reg;
  logic                overflow_next;

  logic                in_ext;
  logic                in_break;
  cmd_e                decoded_cmd;
  logic [NUM_KEYS-1:0] decoded_mask;
  logic                push;
  logic [CMD_W-1:0]    push_cmd;
  logic                fifo_full;
  logic                fifo_empty;

  assign in_ext       = (state_reg == ST_EXT) || (state_reg == ST_EXT_BRK);
  assign in_break     = (state_reg == ST_BRK) || (state_reg == ST_EXT_BRK);
  assign decoded_cmd  = decode_scan(scan_data, in_ext);
  assign decoded_mask = cmd_mask(decoded_cmd);

  always_comb begin
    state_next = state_reg;
    keys_next  = keys_reg;
    push       = 1'b0;
    push_cmd   = CMD_NONE;
    if (scan_valid) begin
      case (scan_data)
        SC_EXT_PREFIX: begin
          state_next = in_break ? ST_EXT_BRK : ST_EXT;
        end
        SC_BREAK_PREFIX: begin
          // A repeated F0 keeps the pending break; it never cancels it.
          if (state_reg == ST_IDLE)     state_next = ST_BRK;
          else if (state_reg == ST_EXT) state_next = ST_EXT_BRK;
        end
        default: begin
          state_next = ST_IDLE;
          if (decoded_cmd != CMD_NONE) begin
            if (in_break) begin
              keys_next = keys_reg & ~decoded_mask;
            end else begin
              keys_next = keys_reg | decoded_mask;
              push      = is_repeatable(decoded_cmd) || ((keys_reg & decoded_mask) == '0);
              push_cmd  = decoded_cmd;
            end
          end
        end
      endcase
    end
  end

  // The FIFO pops whenever cmd_ready is high and it is non-empty, so a push
  // into a full FIFO is lost exactly when cmd_ready is low.
  assign overflow_next = overflow_reg | (push && fifo_full && !cmd_ready);

  always_ff @(posedge inclock or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      keys_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      keys_reg     <= keys_next;
      overflow_reg <= overflow_next;
    end
  end

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .inclock   (inclock),
    .reset     (reset),
    .push      (push),
    .push_data (push_cmd),
    .pop       (cmd_ready),
    .pop_data  (cmd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cmd_valid = !fifo_empty;
  assign keys_held = keys_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_ps2_key_cmd_decoder.sv
// Scoreboard bench: stimulus queues expected commands, a monitor checks each
// handshake against the queue, and directed checks cover flags and boundaries.
module tb_ps2_key_cmd_decoder;

  logic       inclock = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] scan_data  = 8'h00;
  logic       scan_valid = 1'b0;
  logic [2:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready  = 1'b0;
  logic [4:0] keys_held;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  logic [2:0] exp_q [$];
  logic [2:0] mon_exp;

  ps2_key_cmd_decoder #(.FIFO_DEPTH(4)) dut (
    .inclock    (inclock),
    .reset      (reset),
    .scan_data  (scan_data),
    .scan_valid (scan_valid),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .keys_held  (keys_held),
    .overflow   (overflow)
  );

  always #5 inclock = ~inclock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: every accepted pop must match the oldest expected command.
  always @(negedge inclock) begin
    if (!reset && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop: got %0d, expected no entry", cmd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pop", 32'(cmd_data), 32'(mon_exp));
        n_pops++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge inclock); #1;
    scan_data  = b;
    scan_valid = 1'b1;
    @(posedge inclock); #1;
    scan_valid = 1'b0;
  endtask

  task automatic drain();
    cmd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge inclock); #1;
      if (!cmd_valid) break;
    end
    check("drain_empty", 32'(cmd_valid), 32'd0);
    check("empty_data", 32'(cmd_data), 32'd0);
    cmd_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge inclock); #1;
    reset = 1'b1;
    #2;
    check("async_rst_valid", 32'(cmd_valid), 32'd0);
    check("async_rst_keys", 32'(keys_held), 32'd0);
    exp_q.delete();
    @(posedge inclock); #1;
    reset = 1'b0;
  endtask

  initial begin
    int pops_before;
    #2;
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_data", 32'(cmd_data), 32'd0);
    check("rst_keys", 32'(keys_held), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    @(posedge inclock); #1;
    reset = 1'b0;

    // Plain make then break of LEFT
    send_byte(8'h1C); exp_q.push_back(3'd1);
    check("make_valid", 32'(cmd_valid), 32'd1);
    check("make_data", 32'(cmd_data), 32'd1);
    check("make_keys", 32'(keys_held), 32'b00001);
    send_byte(8'hF0); send_byte(8'h1C);
    check("break_keys", 32'(keys_held), 32'b00000);
    pops_before = n_pops;
    drain();
    check("make_pops", 32'(n_pops - pops_before), 32'd1);

    // Extended ROTATE make, then extended break
    send_byte(8'hE0); send_byte(8'h75); exp_q.push_back(3'd5);
    check("ext_data", 32'(cmd_data), 32'd5);
    check("ext_keys", 32'(keys_held), 32'b10000);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check("ext_brk_keys", 32'(keys_held), 32'b00000);
    check("ext_brk_data", 32'(cmd_data), 32'd5);
    pops_before = n_pops;
    drain();
    check("ext_pops", 32'(n_pops - pops_before), 32'd1);

    // Typematic repeats: DROP once, RIGHT three times
    send_byte(8'h29); send_byte(8'h29); send_byte(8'h29); exp_q.push_back(3'd4);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h23); exp_q.push_back(3'd2);
    end
    check("rep_keys", 32'(keys_held), 32'b01010);
    check("rep_ovf", 32'(overflow), 32'd0);
    pops_before = n_pops;
    drain();
    check("rep_pops", 32'(n_pops - pops_before), 32'd4);
    send_byte(8'hF0); send_byte(8'h29); send_byte(8'hF0); send_byte(8'h23);
    check("rep_release", 32'(keys_held), 32'b00000);

    // Overflow: five LEFT makes into a depth-4 FIFO
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h1C);
      if (i < 4) exp_q.push_back(3'd1);
    end
    check("ovf_flag", 32'(overflow), 32'd1);
    pops_before = n_pops;
    drain();
    check("ovf_pops", 32'(n_pops - pops_before), 32'd4);
    check("ovf_sticky", 32'(overflow), 32'd1);
    pulse_reset();
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Full boundary: push DOWN and pop together while full
    send_byte(8'h1C); exp_q.push_back(3'd1);
    send_byte(8'h23); exp_q.push_back(3'd2);
    send_byte(8'h1C); exp_q.push_back(3'd1);
    send_byte(8'h23); exp_q.push_back(3'd2);
    @(posedge inclock); #1;
    scan_data  = 8'h1B;
    scan_valid = 1'b1;
    cmd_ready  = 1'b1;
    exp_q.push_back(3'd3);
    @(posedge inclock); #1;
    scan_valid = 1'b0;
    cmd_ready  = 1'b0;
    check("full_ovf", 32'(overflow), 32'd0);
    check("full_valid", 32'(cmd_valid), 32'd1);
    pops_before = n_pops;
    drain();
    check("full_count", 32'(n_pops - pops_before), 32'd4);

    // Reset discards a pending E0 prefix
    send_byte(8'h1D); exp_q.push_back(3'd5);
    send_byte(8'hE0);
    pulse_reset();
    send_byte(8'h74);
    check("rstpfx_valid", 32'(cmd_valid), 32'd0);
    check("rstpfx_data", 32'(cmd_data), 32'd0);
    check("rstpfx_keys", 32'(keys_held), 32'd0);
    check("rstpfx_ovf", 32'(overflow), 32'd0);

    check("scoreboard_left", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
